// File: rtl/sfp_tx_fifo_pkg.sv
// Shared SFP constants and types used by the TX-path stream FIFOs.
package sfp_tx_fifo_pkg;

    localparam int SFP_DATA_WIDTH       = 64;
    localparam int SFP_PEER_FIFO_DEPTH  = 64;
    // Local path must absorb at least 9 periodic status words per period.
    localparam int SFP_LOCAL_FIFO_DEPTH = 64;
    localparam int SFP_OVF_WIDTH        = 16;

    typedef logic [SFP_DATA_WIDTH-1:0] sfp_word_t;

endpackage

// File: rtl/sfp_tx_fifo_if.sv
// AXI-Stream style handshake bundle; master drives data/valid, slave drives ready.
interface sfp_tx_fifo_if
    import sfp_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SFP_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/sfp_tx_fifo.sv
// First-word-fall-through stream FIFO feeding the SFP handler transmit arbiter,
// with occupancy reporting and saturating overflow bookkeeping.
module sfp_tx_fifo
    import sfp_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SFP_DATA_WIDTH,
    parameter int DEPTH      = SFP_PEER_FIFO_DEPTH,
    parameter int OVF_WIDTH  = SFP_OVF_WIDTH
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_ovf_clr,
    sfp_tx_fifo_if.slave         s_axis,
    sfp_tx_fifo_if.master        m_axis,
    output logic [31:0]          o_wr_data_cnt,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [OVF_WIDTH-1:0] o_ovf_cnt,
    output logic                 o_ovf_flag
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0]    PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]    CNT_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [OVF_WIDTH-1:0] OVF_ONE = OVF_WIDTH'(1);

    function automatic logic [OVF_WIDTH-1:0] ovf_sat_inc(input logic [OVF_WIDTH-1:0] v);
        if (&v)
            return v;
        return v + OVF_ONE;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W:0] wr_ptr_q;
    logic [ADDR_W:0] rd_ptr_q;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_nxt;
    logic            full_q;
    logic            empty_q;

    logic push;
    logic pop;
    logic drop;

    assign push = s_axis.tvalid && !full_q;
    assign pop  = m_axis.tready && !empty_q;
    assign drop = s_axis.tvalid && full_q && !i_flush;

    assign s_axis.tready = ~full_q;
    assign m_axis.tvalid = ~empty_q;
    assign m_axis.tdata  = mem[rd_ptr_q[ADDR_W-1:0]];

    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_wr_data_cnt = 32'(count_q);

    always_comb begin
        count_nxt = count_q;
        if (push && !pop)
            count_nxt = count_q + PTR_ONE;
        else if (pop && !push)
            count_nxt = count_q - PTR_ONE;
    end

    // Storage is data only: no reset, so it maps onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (push && !i_flush)
            mem[wr_ptr_q[ADDR_W-1:0]] <= s_axis.tdata;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_DEPTH);
            empty_q <= (count_nxt == '0);
        end
    end

    // Clear wins over a same-cycle drop; flush leaves the overflow history alone.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_ovf_cnt  <= '0;
            o_ovf_flag <= 1'b0;
        end else if (i_ovf_clr) begin
            o_ovf_cnt  <= '0;
            o_ovf_flag <= 1'b0;
        end else if (drop) begin
            o_ovf_cnt  <= ovf_sat_inc(o_ovf_cnt);
            o_ovf_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sfp_tx_fifo.sv
// Scoreboard bench for sfp_tx_fifo at DEPTH = 8.
module tb_sfp_tx_fifo;
    import sfp_tx_fifo_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int OW    = 16;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          ovf_clr;
    logic [31:0]   wr_cnt;
    logic          full;
    logic          empty;
    logic [OW-1:0] ovf_cnt;
    logic          ovf_flag;

    sfp_tx_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    sfp_tx_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    sfp_tx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .OVF_WIDTH  (OW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_flush       (flush),
        .i_ovf_clr     (ovf_clr),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .o_wr_data_cnt (wr_cnt),
        .o_full        (full),
        .o_empty       (empty),
        .o_ovf_cnt     (ovf_cnt),
        .o_ovf_flag    (ovf_flag)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word the handler takes; the pop lands on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && !flush && m_if.tvalid && m_if.tready)
            obs_q.push_back(m_if.tdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        flush       = 1'b0;
        ovf_clr     = 1'b0;
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_if.tdata  = base + DW'(i);
            s_if.tvalid = 1'b1;
            exp_q.push_back(base + DW'(i));
            tick();
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic pop_cycles(input int n);
        m_if.tready = 1'b1;
        for (int i = 0; i < n; i++)
            tick();
        m_if.tready = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] got;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (wr_cnt !== 32'd0 || empty !== 1'b1 || full !== 1'b0 || s_if.tready !== 1'b1 ||
            m_if.tvalid !== 1'b0 || ovf_cnt !== '0 || ovf_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: cnt=%0d empty=%b full=%b rdy=%b vld=%b ovf=%0d flag=%b, want 0 1 0 1 0 0 0",
                     wr_cnt, empty, full, s_if.tready, m_if.tvalid, ovf_cnt, ovf_flag);
        end
        rst_n = 1'b1;
        tick();
        got = '0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] got, want;
        s_if.tdata  = 64'h1;
        s_if.tvalid = 1'b1;
        exp_q.push_back(64'h1);
        tick();
        s_if.tvalid = 1'b0;
        vectors++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'h1 || wr_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL first_push_latency: vld=%b data=%h cnt=%0d, want 1 1 1", m_if.tvalid, m_if.tdata, wr_cnt);
        end
        push_words(64'h2, 2);
        vectors++;
        if (wr_cnt !== 32'd3 || m_if.tdata !== 64'h1 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_fill: cnt=%0d head=%h empty=%b, want 3 1 0", wr_cnt, m_if.tdata, empty);
        end
        pop_cycles(3);
        vectors++;
        if (empty !== 1'b1 || wr_cnt !== 32'd0 || m_if.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: empty=%b cnt=%0d vld=%b, want 1 0 0", empty, wr_cnt, m_if.tvalid);
        end
        vectors++;
        if (obs_q.size() != 3) begin
            miscompares++;
            $display("FAIL basic_pop_count: got %0d words, want 3", obs_q.size());
        end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL basic_order: got %h, want %h", got, want);
            end
        end
    endtask

    task automatic test_overflow();
        push_words(64'h100, DEPTH);
        vectors++;
        if (full !== 1'b1 || s_if.tready !== 1'b0 || wr_cnt !== 32'(DEPTH)) begin
            miscompares++;
            $display("FAIL fill_to_full: full=%b rdy=%b cnt=%0d, want 1 0 %0d", full, s_if.tready, wr_cnt, DEPTH);
        end
        s_if.tdata  = 64'hDEAD;
        s_if.tvalid = 1'b1;
        tick();
        tick();
        s_if.tvalid = 1'b0;
        vectors++;
        if (ovf_cnt !== 16'd2 || ovf_flag !== 1'b1 || full !== 1'b1 || wr_cnt !== 32'(DEPTH)) begin
            miscompares++;
            $display("FAIL overflow_count: ovf=%0d flag=%b full=%b cnt=%0d, want 2 1 1 %0d",
                     ovf_cnt, ovf_flag, full, wr_cnt, DEPTH);
        end
        // Clear together with a further drop: clear must win.
        ovf_clr     = 1'b1;
        s_if.tvalid = 1'b1;
        tick();
        ovf_clr     = 1'b0;
        s_if.tvalid = 1'b0;
        vectors++;
        if (ovf_cnt !== 16'd0 || ovf_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_priority: ovf=%0d flag=%b, want 0 0", ovf_cnt, ovf_flag);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] got, want;
        s_if.tdata  = 64'hBEEF;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        vectors++;
        if (ovf_cnt !== 16'd1 || wr_cnt !== 32'(DEPTH-1) || s_if.tready !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_push_pop: ovf=%0d cnt=%0d rdy=%b full=%b, want 1 %0d 1 0",
                     ovf_cnt, wr_cnt, s_if.tready, full, DEPTH-1);
        end
        pop_cycles(DEPTH-1);
        vectors++;
        if (empty !== 1'b1 || obs_q.size() != DEPTH) begin
            miscompares++;
            $display("FAIL full_drain: empty=%b words=%0d, want 1 %0d", empty, obs_q.size(), DEPTH);
        end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL full_order: got %h, want %h", got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got, want;
        push_words(64'h200, 4);
        for (int i = 0; i < 20; i++) begin
            s_if.tdata  = 64'h300 + DW'(i);
            s_if.tvalid = 1'b1;
            m_if.tready = 1'b1;
            exp_q.push_back(64'h300 + DW'(i));
            tick();
            vectors++;
            if (wr_cnt !== 32'd4 || m_if.tvalid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_steady cycle %0d: cnt=%0d vld=%b, want 4 1", i, wr_cnt, m_if.tvalid);
            end
        end
        s_if.tvalid = 1'b0;
        pop_cycles(4);
        vectors++;
        if (empty !== 1'b1 || obs_q.size() != 24) begin
            miscompares++;
            $display("FAIL b2b_drain: empty=%b words=%0d, want 1 24", empty, obs_q.size());
        end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL b2b_order: got %h, want %h", got, want);
            end
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] got, want;
        logic [OW-1:0] ovf_before;
        push_words(64'h400, 5);
        ovf_before  = ovf_cnt;
        flush       = 1'b1;
        s_if.tdata  = 64'h4FF;
        s_if.tvalid = 1'b1;
        exp_q.delete();
        tick();
        flush       = 1'b0;
        s_if.tvalid = 1'b0;
        vectors++;
        if (wr_cnt !== 32'd0 || m_if.tvalid !== 1'b0 || empty !== 1'b1 || ovf_cnt !== ovf_before) begin
            miscompares++;
            $display("FAIL flush_state: cnt=%0d vld=%b empty=%b ovf=%0d, want 0 0 1 %0d",
                     wr_cnt, m_if.tvalid, empty, ovf_cnt, ovf_before);
        end
        push_words(64'h500, 1);
        vectors++;
        if (m_if.tdata !== 64'h500 || wr_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL flush_restart: head=%h cnt=%0d, want 500 1", m_if.tdata, wr_cnt);
        end
        pop_cycles(1);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL flush_order: got %h, want %h", got, want);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] got, want;
        push_words(64'h600, 6);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        vectors++;
        if (wr_cnt !== 32'd0 || m_if.tvalid !== 1'b0 || empty !== 1'b1 || s_if.tready !== 1'b1 ||
            ovf_cnt !== '0 || ovf_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: cnt=%0d vld=%b empty=%b rdy=%b ovf=%0d flag=%b, want 0 0 1 1 0 0",
                     wr_cnt, m_if.tvalid, empty, s_if.tready, ovf_cnt, ovf_flag);
        end
        tick();
        rst_n = 1'b1;
        tick();
        push_words(64'h700, 2);
        pop_cycles(2);
        vectors++;
        if (obs_q.size() != 2 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_restart: words=%0d empty=%b, want 2 1", obs_q.size(), empty);
        end
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_order: got %h, want %h", got, want);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
